clock_divider: RTL and testbench
================================

Name: clock_divider

Overview:
- Derives two 50%-duty divided clocks from the 50 MHz board clock: CLK_100Hz (display/stopwatch timebase) and CLK_1Hz (seconds timebase).
- Sits at the top of the timer design; all timer logic consumes its outputs.
- CLK_1Hz is generated from CLK_100Hz toggle events, so every CLK_1Hz edge coincides with a CLK_100Hz edge.
- Both outputs are registered and glitch-free.

Parameters:
- CLK_FREQ_HZ, 50000000, input clock frequency in Hz.
- FAST_HZ, 100, frequency of CLK_100Hz in Hz.
- SLOW_HZ, 1, frequency of CLK_1Hz in Hz.
- Derived constant HALF_FAST = CLK_FREQ_HZ/(2*FAST_HZ), default 250000.
- Derived constant RATIO = FAST_HZ/SLOW_HZ, default 100, counted in CLK_100Hz toggles.
- Legal configurations: CLK_FREQ_HZ divisible by 2*FAST_HZ; FAST_HZ divisible by SLOW_HZ; HALF_FAST >= 1; RATIO >= 1. Any other configuration is unsupported.

Ports:
- CLK_50MHz  input  1  system clock; all logic updates on its rising edge.
- rst_n  input  1  synchronous reset, active-high (1 = reset), sampled on the rising edge of CLK_50MHz.
- CLK_100Hz  output  1  divided clock at FAST_HZ, 50% duty.
- CLK_1Hz  output  1  divided clock at SLOW_HZ, 50% duty.

Behaviour:
- Single clock domain; no asynchronous paths.
- Fast counter fcnt:
  - width clog2(HALF_FAST), minimum 1; 18 bits at default.
  - counts 0..HALF_FAST-1.
- Slow counter scnt:
  - width clog2(RATIO), minimum 1; 7 bits at default.
  - counts 0..RATIO-1.
- Reset:
  - With rst_n=1 at a rising edge, fcnt=0, scnt=0, CLK_100Hz=0, CLK_1Hz=0.
  - Reset has priority over all counting.
  - Outputs stay 0 for as long as rst_n is held high.
  - Asserting reset mid-period aborts the period immediately at the next edge. No partial-phase memory is kept.
- Fast path, each edge with rst_n=0:
  - If fcnt==HALF_FAST-1, then fcnt<=0 and CLK_100Hz toggles (a fast toggle event).
  - Otherwise fcnt increments.
- Slow path, evaluated only on fast toggle events:
  - If scnt==RATIO-1, then scnt<=0 and CLK_1Hz toggles on the same edge.
  - Otherwise scnt increments.
- Timing from reset release (first edge with rst_n=0 counts as edge 1):
  - first CLK_100Hz rise at edge HALF_FAST (250000, i.e. 5 ms);
  - first CLK_1Hz rise at edge HALF_FAST*RATIO (25,000,000, i.e. 0.5 s).
  - Output period: CLK_100Hz = 2*HALF_FAST edges; CLK_1Hz = 2*HALF_FAST*RATIO edges.
  - Exactly 50% duty.
- Wrap-around: both counters wrap silently and never overflow their widths.
- Simultaneous events: when both terminal counts hit on one edge, both outputs toggle on that edge.
- Output phase: outputs are direct flop outputs with no combinational decode.

Test Plan:
- Default params; rst_n=1 for 2500 cycles -> CLK_100Hz=0, CLK_1Hz=0 throughout.
- Default params; rst_n=0 for 2500 cycles (50 us) -> no toggle (2500 < 250000); then rst_n=1 for 2500 cycles -> outputs held 0; then rst_n=0 -> bench stays clean.
- CLK_FREQ_HZ=1000, FAST_HZ=100, SLOW_HZ=10 (HALF_FAST=5, RATIO=10); release reset -> CLK_100Hz rises at edge 5, falls at edge 10, period 10 edges; CLK_1Hz rises at edge 50, falls at edge 100.
- Same scaled params; run 1000 edges -> CLK_100Hz has 100 rising edges, CLK_1Hz has 10; high time equals low time on both; every CLK_1Hz edge coincides with a CLK_100Hz edge.
- Same scaled params; assert rst_n=1 at edge 37 (mid-period) for 1 cycle -> both outputs 0 on the next edge; after release, CLK_100Hz rises 5 edges and CLK_1Hz 50 edges later.
- Degenerate CLK_FREQ_HZ=2, FAST_HZ=1, SLOW_HZ=1 (HALF_FAST=1, RATIO=1) -> CLK_100Hz toggles every edge; CLK_1Hz identical to CLK_100Hz.

Source files
------------

// File: rtl/clock_divider.sv
// Divides the board clock into two registered 50%-duty clocks. The slow
// output advances only on fast toggle events, so its edges align with fast edges.
module clock_divider #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int FAST_HZ     = 100,
  parameter int SLOW_HZ     = 1
) (
  input  logic CLK_50MHz,
  input  logic rst_n,
  output logic CLK_100Hz,
  output logic CLK_1Hz
);

  localparam int HALF_FAST = CLK_FREQ_HZ / (2 * FAST_HZ);
  localparam int RATIO     = FAST_HZ / SLOW_HZ;
  localparam int FW        = (HALF_FAST > 1) ? $clog2(HALF_FAST) : 1;
  localparam int SW        = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [FW-1:0] FAST_TC = FW'(HALF_FAST - 1);
  localparam logic [SW-1:0] SLOW_TC = SW'(RATIO - 1);

  logic [FW-1:0] fcnt;
  logic [SW-1:0] scnt;
  logic          fast_tc;
  logic          slow_tc;

  assign fast_tc = (fcnt == FAST_TC);
  assign slow_tc = (scnt == SLOW_TC);

  // rst_n is active-high despite its name; it overrides all counting.
  always_ff @(posedge CLK_50MHz) begin
    if (rst_n) begin
      fcnt      <= '0;
      scnt      <= '0;
      CLK_100Hz <= 1'b0;
      CLK_1Hz   <= 1'b0;
    end else if (fast_tc) begin
      fcnt      <= '0;
      CLK_100Hz <= ~CLK_100Hz;
      if (slow_tc) begin
        scnt    <= '0;
        CLK_1Hz <= ~CLK_1Hz;
      end else begin
        scnt <= scnt + SW'(1);
      end
    end else begin
      fcnt <= fcnt + FW'(1);
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: default, scaled and degenerate
// configurations, each checked edge by edge against a closed-form model.
module tb_clock_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, rst_s, rst_g;
  logic f_d, s_d, f_s, s_s, f_g, s_g;

  clock_divider dut_def (
    .CLK_50MHz(clk), .rst_n(rst_d), .CLK_100Hz(f_d), .CLK_1Hz(s_d));

  clock_divider #(.CLK_FREQ_HZ(1000), .FAST_HZ(100), .SLOW_HZ(10)) dut_sc (
    .CLK_50MHz(clk), .rst_n(rst_s), .CLK_100Hz(f_s), .CLK_1Hz(s_s));

  clock_divider #(.CLK_FREQ_HZ(2), .FAST_HZ(1), .SLOW_HZ(1)) dut_dg (
    .CLK_50MHz(clk), .rst_n(rst_g), .CLK_100Hz(f_g), .CLK_1Hz(s_g));

  int total = 0;
  int bad   = 0;
  logic [1:0] sb[$];

  // Expected {fast, slow} after the n-th edge since reset release.
  function automatic logic [1:0] model(int n, int hf, int r);
    logic [1:0] m;
    m = 2'b00;
    if (n > 0) begin
      m[1] = ((n / hf) % 2) == 1;
      m[0] = ((n / (hf * r)) % 2) == 1;
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_d = 0;
  int n_s = 0;
  int n_g = 0;

  task automatic test_reset();
    logic [1:0] e;
    rst_d = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      n_d = 0;
      sb.push_back(model(n_d, 250000, 100));
      tick();
      e = sb.pop_front();
      total++;
      if ({f_d, s_d} !== e) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, {f_d, s_d}, e);
      end
    end
  endtask

  task automatic test_default_hold();
    logic [1:0] e;
    for (int ph = 0; ph < 3; ph++) begin
      rst_d = (ph == 1);
      for (int i = 0; i < ((ph == 2) ? 300 : 2500); i++) begin
        n_d = rst_d ? 0 : n_d + 1;
        sb.push_back(model(n_d, 250000, 100));
        tick();
        e = sb.pop_front();
        total++;
        if ({f_d, s_d} !== e) begin
          bad++;
          $display("FAIL default_phase%0d cyc=%0d got=%b exp=%b", ph, i, {f_d, s_d}, e);
        end
      end
    end
  endtask

  task automatic test_scaled_timing();
    logic [1:0] e;
    logic pf, ps;
    int fr1, ff1, fr2, sr1, sf1;
    fr1 = -1; ff1 = -1; fr2 = -1; sr1 = -1; sf1 = -1;
    rst_s = 1'b1;
    n_s = 0;
    tick();
    pf = f_s; ps = s_s;
    total++;
    if ({f_s, s_s} !== 2'b00) begin
      bad++;
      $display("FAIL scaled_reset got=%b exp=00", {f_s, s_s});
    end
    rst_s = 1'b0;
    for (int i = 1; i <= 110; i++) begin
      n_s = n_s + 1;
      sb.push_back(model(n_s, 5, 10));
      tick();
      e = sb.pop_front();
      total++;
      if ({f_s, s_s} !== e) begin
        bad++;
        $display("FAIL scaled_edge n=%0d got=%b exp=%b", i, {f_s, s_s}, e);
      end
      if (!pf && f_s) begin
        if (fr1 < 0) fr1 = i; else if (fr2 < 0) fr2 = i;
      end
      if (pf && !f_s && ff1 < 0) ff1 = i;
      if (!ps && s_s && sr1 < 0) sr1 = i;
      if (ps && !s_s && sf1 < 0) sf1 = i;
      pf = f_s; ps = s_s;
    end
    total++;
    if (fr1 !== 5) begin bad++; $display("FAIL fast_first_rise got=%0d exp=5", fr1); end
    total++;
    if (ff1 !== 10) begin bad++; $display("FAIL fast_first_fall got=%0d exp=10", ff1); end
    total++;
    if (fr2 !== 15) begin bad++; $display("FAIL fast_period got=%0d exp=15", fr2); end
    total++;
    if (sr1 !== 50) begin bad++; $display("FAIL slow_first_rise got=%0d exp=50", sr1); end
    total++;
    if (sf1 !== 100) begin bad++; $display("FAIL slow_first_fall got=%0d exp=100", sf1); end
  endtask

  task automatic test_scaled_run();
    logic [1:0] e;
    logic pf, ps;
    int frise, srise, fhi, flo, shi, slo, misalign;
    frise = 0; srise = 0; fhi = 0; flo = 0; shi = 0; slo = 0; misalign = 0;
    rst_s = 1'b1;
    tick();
    n_s = 0;
    pf = f_s; ps = s_s;
    rst_s = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      n_s = n_s + 1;
      sb.push_back(model(n_s, 5, 10));
      tick();
      e = sb.pop_front();
      total++;
      if ({f_s, s_s} !== e) begin
        bad++;
        $display("FAIL run_edge n=%0d got=%b exp=%b", i, {f_s, s_s}, e);
      end
      if (!pf && f_s) frise++;
      if (!ps && s_s) srise++;
      if (f_s) fhi++; else flo++;
      if (s_s) shi++; else slo++;
      if ((ps != s_s) && (pf == f_s)) misalign++;
      pf = f_s; ps = s_s;
    end
    total++;
    if (frise !== 100) begin bad++; $display("FAIL fast_rises got=%0d exp=100", frise); end
    total++;
    if (srise !== 10) begin bad++; $display("FAIL slow_rises got=%0d exp=10", srise); end
    total++;
    if (fhi !== 500 || flo !== 500) begin
      bad++; $display("FAIL fast_duty hi=%0d lo=%0d exp=500/500", fhi, flo);
    end
    total++;
    if (shi !== 500 || slo !== 500) begin
      bad++; $display("FAIL slow_duty hi=%0d lo=%0d exp=500/500", shi, slo);
    end
    total++;
    if (misalign !== 0) begin bad++; $display("FAIL edge_align got=%0d exp=0", misalign); end
  endtask

  task automatic test_mid_reset();
    logic [1:0] e;
    logic pf, ps;
    int fr, sr;
    rst_s = 1'b1;
    tick();
    n_s = 0;
    rst_s = 1'b0;
    for (int i = 1; i <= 36; i++) begin
      n_s = n_s + 1;
      sb.push_back(model(n_s, 5, 10));
      tick();
      e = sb.pop_front();
      total++;
      if ({f_s, s_s} !== e) begin
        bad++;
        $display("FAIL pre_abort n=%0d got=%b exp=%b", i, {f_s, s_s}, e);
      end
    end
    rst_s = 1'b1;
    n_s = 0;
    sb.push_back(model(n_s, 5, 10));
    tick();
    e = sb.pop_front();
    total++;
    if ({f_s, s_s} !== e) begin
      bad++;
      $display("FAIL abort_edge got=%b exp=%b", {f_s, s_s}, e);
    end
    rst_s = 1'b0;
    fr = -1; sr = -1; pf = f_s; ps = s_s;
    for (int i = 1; i <= 60; i++) begin
      n_s = n_s + 1;
      sb.push_back(model(n_s, 5, 10));
      tick();
      e = sb.pop_front();
      total++;
      if ({f_s, s_s} !== e) begin
        bad++;
        $display("FAIL post_abort n=%0d got=%b exp=%b", i, {f_s, s_s}, e);
      end
      if (!pf && f_s && fr < 0) fr = i;
      if (!ps && s_s && sr < 0) sr = i;
      pf = f_s; ps = s_s;
    end
    total++;
    if (fr !== 5) begin bad++; $display("FAIL restart_fast_rise got=%0d exp=5", fr); end
    total++;
    if (sr !== 50) begin bad++; $display("FAIL restart_slow_rise got=%0d exp=50", sr); end
  endtask

  task automatic test_degenerate();
    logic [1:0] e;
    rst_g = 1'b1;
    tick();
    n_g = 0;
    total++;
    if ({f_g, s_g} !== 2'b00) begin
      bad++;
      $display("FAIL degen_reset got=%b exp=00", {f_g, s_g});
    end
    rst_g = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      n_g = n_g + 1;
      sb.push_back(model(n_g, 1, 1));
      tick();
      e = sb.pop_front();
      total++;
      if ({f_g, s_g} !== e) begin
        bad++;
        $display("FAIL degen_edge n=%0d got=%b exp=%b", i, {f_g, s_g}, e);
      end
    end
  endtask

  initial begin
    rst_d = 1'b1;
    rst_s = 1'b1;
    rst_g = 1'b1;
    test_reset();
    test_default_hold();
    test_scaled_timing();
    test_scaled_run();
    test_mid_reset();
    test_degenerate();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
